// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   CTRLBUS_IF      : this stage's bit in the 6-bit pipeline stall/flush buses
//   FAULT_MISALIGN  : inst_fault_o bit flagging a misaligned PC
//   FAULT_ACCESS    : inst_fault_o bit flagging an icache access fault
//   NOP_INST        : instruction emitted in place of a faulting fetch
//   if_state_e      : fetch control state (RUN issues, DRAIN discards stale responses)
package if_fetch_pkg;

  localparam int unsigned CTRLBUS_W      = 6;
  localparam int unsigned CTRLBUS_IF     = 1;
  localparam int unsigned FAULT_MISALIGN = 1;
  localparam int unsigned FAULT_ACCESS   = 0;
  localparam logic [31:0] NOP_INST       = 32'h0000_0013;

  typedef enum logic [0:0] {
    IF_RUN   = 1'b0,
    IF_DRAIN = 1'b1
  } if_state_e;

  // Packs the two fault flags into the {misaligned, access_fault} field.
  function automatic logic [1:0] fault_bits(input logic misaligned, input logic access);
    logic [1:0] f;
    f                 = '0;
    f[FAULT_MISALIGN] = misaligned;
    f[FAULT_ACCESS]   = access;
    return f;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with asynchronous active-low reset and synchronous clear.
//   clk, rst_n  : clock / async active-low reset
//   clr         : empties the FIFO (wins over push and pop)
//   push, push_data : write when not full
//   pop         : advance the head when not empty
//   head        : current head entry (valid while count != 0)
//   count       : number of stored entries
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit so that
// full and empty are told apart by the MSB.
module if_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: nothing reads it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage between the PC register and IF/ID.
//   clk, rst                      : clock / async active-low reset
//   stall_valid_i, flush_valid_i  : pipeline control buses (bit CTRLBUS_IF used)
//   fetch_pc_i, fetch_req_i       : next fetch address and request from the PC register
//   pc_stall_req_o                : address not taken this cycle, PC register must hold
//   ic_req_valid_o/ready_i/addr_o : icache request channel
//   ic_resp_valid_i/data_i/err_i  : icache responses, in order, never backpressured
//   inst_valid_o/inst_o/inst_pc_o/inst_fault_o/inst_ready_i : result queue head to decode
// Requests are credit-limited so every response has a reserved queue slot. After
// a flush, responses still in flight are counted down and discarded (DRAIN).
module if_fetch #(
  parameter int unsigned XLEN            = 64,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned QDEPTH          = 2,
  parameter logic [31:0] NOP_INST        = if_fetch_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      stall_valid_i,
  input  logic [5:0]      flush_valid_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  input  logic            fetch_req_i,
  output logic            pc_stall_req_o,
  output logic            ic_req_valid_o,
  input  logic            ic_req_ready_i,
  output logic [XLEN-1:0] ic_req_addr_o,
  input  logic            ic_resp_valid_i,
  input  logic [31:0]     ic_resp_data_i,
  input  logic            ic_resp_err_i,
  output logic            inst_valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic [1:0]      inst_fault_o,
  input  logic            inst_ready_i
);

  import if_fetch_pkg::*;

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned QW = $clog2(QDEPTH);
  localparam int unsigned EW = 32 + XLEN + 2;

  logic [OW:0]      outstanding;
  logic [XLEN-1:0]  pend_pc;
  logic [QW:0]      q_count;
  logic [EW-1:0]    q_head;
  logic [EW-1:0]    q_push_data;
  logic [OW:0]      drop_cnt;
  logic [OW:0]      drop_next;
  if_state_e        state;
  if_state_e        state_next;

  logic             flush;
  logic             stall;
  logic             aligned;
  logic             q_valid;
  logic             q_pop;
  logic             q_push;
  logic             resp_keep;
  logic             resp_drop;
  logic             run_ok;
  logic             credit;
  logic             handshake;
  logic             mis_accept;
  int unsigned      occupancy;

  logic             unused_ok;
  assign unused_ok = ^{stall_valid_i, flush_valid_i};

  assign flush   = flush_valid_i[CTRLBUS_IF];
  assign stall   = stall_valid_i[CTRLBUS_IF];
  assign aligned = (fetch_pc_i[1:0] == 2'b00);
  assign q_valid = (q_count != '0);
  assign q_pop   = q_valid & inst_ready_i & ~stall;

  assign resp_keep = ic_resp_valid_i & (drop_cnt == '0) & ~flush;
  assign resp_drop = ic_resp_valid_i & ~resp_keep;

  // Slots committed to in-flight requests plus queued results. A head leaving
  // this cycle frees its slot before any new request can come back, so it is
  // credited immediately to sustain one fetch per cycle.
  assign occupancy = 32'(outstanding) + 32'(q_count) - 32'(q_pop);
  assign credit    = (occupancy < QDEPTH) && (32'(outstanding) < MAX_OUTSTANDING);
  assign run_ok    = rst & (state == IF_RUN) & ~flush;

  assign ic_req_valid_o = fetch_req_i & credit & run_ok & aligned;
  assign ic_req_addr_o  = fetch_pc_i;
  assign handshake      = ic_req_valid_o & ic_req_ready_i;

  // Misaligned PCs never reach the icache; they wait for all older requests
  // to retire so the fault lands in program order.
  assign mis_accept = fetch_req_i & run_ok & ~aligned & (outstanding == '0) &
                      (occupancy < QDEPTH);

  assign pc_stall_req_o = rst & fetch_req_i & ~(handshake | mis_accept);

  assign q_push      = resp_keep | mis_accept;
  assign q_push_data = mis_accept
                     ? {fault_bits(1'b1, 1'b0), fetch_pc_i, NOP_INST}
                     : {fault_bits(1'b0, ic_resp_err_i), pend_pc,
                        (ic_resp_err_i ? NOP_INST : ic_resp_data_i)};

  // Pending-PC FIFO: its occupancy is the outstanding-request count. Every
  // response pops it, kept or dropped, so tags stay aligned across flushes.
  if_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pend_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .clr       (1'b0),
    .push      (handshake),
    .push_data (fetch_pc_i),
    .pop       (ic_resp_valid_i),
    .head      (pend_pc),
    .count     (outstanding)
  );

  if_fifo #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_result_q (
    .clk       (clk),
    .rst_n     (rst),
    .clr       (flush),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count)
  );

  assign inst_valid_o = q_valid;
  assign inst_o       = q_valid ? q_head[31:0]      : NOP_INST;
  assign inst_pc_o    = q_valid ? q_head[32 +: XLEN] : '0;
  assign inst_fault_o = q_valid ? q_head[EW-1 -: 2]  : '0;

  always_comb begin
    drop_next  = drop_cnt;
    state_next = state;
    if (flush) begin
      // A response arriving with the flush is discarded right now.
      drop_next  = outstanding - {{OW{1'b0}}, ic_resp_valid_i};
      state_next = (drop_next != '0) ? IF_DRAIN : IF_RUN;
    end else if (resp_drop) begin
      drop_next  = drop_cnt - (OW+1)'(1);
      state_next = (drop_next == '0) ? IF_RUN : state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
      state    <= IF_RUN;
    end else begin
      drop_cnt <= drop_next;
      state    <= state_next;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned CIF = if_fetch_pkg::CTRLBUS_IF;

  logic        clk;
  logic        rst;
  logic [5:0]  stall_valid_i;
  logic [5:0]  flush_valid_i;
  logic [63:0] fetch_pc_i;
  logic        fetch_req_i;
  logic        pc_stall_req_o;
  logic        ic_req_valid_o;
  logic        ic_req_ready_i;
  logic [63:0] ic_req_addr_o;
  logic        ic_resp_valid_i;
  logic [31:0] ic_resp_data_i;
  logic        ic_resp_err_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic [1:0]  inst_fault_o;
  logic        inst_ready_i;

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  if_fetch #(
    .XLEN            (64),
    .MAX_OUTSTANDING (2),
    .QDEPTH          (2),
    .NOP_INST        (NOP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_valid_i   (stall_valid_i),
    .flush_valid_i   (flush_valid_i),
    .fetch_pc_i      (fetch_pc_i),
    .fetch_req_i     (fetch_req_i),
    .pc_stall_req_o  (pc_stall_req_o),
    .ic_req_valid_o  (ic_req_valid_o),
    .ic_req_ready_i  (ic_req_ready_i),
    .ic_req_addr_o   (ic_req_addr_o),
    .ic_resp_valid_i (ic_resp_valid_i),
    .ic_resp_data_i  (ic_resp_data_i),
    .ic_resp_err_i   (ic_resp_err_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
    .inst_fault_o    (inst_fault_o),
    .inst_ready_i    (inst_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus and the outputs expected during that cycle.
  typedef struct {
    logic        fr;
    logic [63:0] pc;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        re;
    logic        ir;
    logic        st;
    logic        fl;
    logic        e_stall;
    logic        e_req;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic [1:0]  e_flt;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Inputs applied at the negedge, outputs sampled 1ns later, then on to the next negedge.
  task automatic step(input string tag, input vec_t v);
    string t;
    t = $sformatf("%s#%0d", tag, step_no);
    step_no++;
    fetch_req_i     = v.fr;
    fetch_pc_i      = v.pc;
    ic_req_ready_i  = v.rdy;
    ic_resp_valid_i = v.rv;
    ic_resp_data_i  = v.rd;
    ic_resp_err_i   = v.re;
    inst_ready_i    = v.ir;
    stall_valid_i   = '0;
    flush_valid_i   = '0;
    stall_valid_i[CIF] = v.st;
    flush_valid_i[CIF] = v.fl;
    #1;
    chk({t, ".pc_stall"},   pc_stall_req_o, v.e_stall);
    chk({t, ".req_valid"},  ic_req_valid_o, v.e_req);
    if (v.e_req) chk({t, ".req_addr"}, ic_req_addr_o, v.pc);
    chk({t, ".inst_valid"}, inst_valid_o, v.e_iv);
    if (v.e_iv) begin
      chk({t, ".inst"},  inst_o,       v.e_inst);
      chk({t, ".pc"},    inst_pc_o,    v.e_pc);
      chk({t, ".fault"}, inst_fault_o, v.e_flt);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_valid"},  ic_req_valid_o, 1'b0);
    chk({tag, ".pc_stall"},   pc_stall_req_o, 1'b0);
    chk({tag, ".inst_valid"}, inst_valid_o,   1'b0);
    chk({tag, ".inst"},       inst_o,         NOP);
    chk({tag, ".pc"},         inst_pc_o,      64'h0);
    chk({tag, ".fault"},      inst_fault_o,   2'b00);
  endtask

  initial begin
    // Zero-wait back-to-back fetches, then a misaligned PC and an access fault.
    tbl[0]  = '{H, 64'h80000000, H, L, 32'h0,        L, H, L, L, L, H, L, 32'h0,        64'h0,        2'b00};
    tbl[1]  = '{H, 64'h80000004, H, H, 32'h00100093, L, H, L, L, L, H, L, 32'h0,        64'h0,        2'b00};
    tbl[2]  = '{H, 64'h80000008, H, H, 32'h00200113, L, H, L, L, L, H, H, 32'h00100093, 64'h80000000, 2'b00};
    tbl[3]  = '{L, 64'h0,        H, H, 32'h00300193, L, H, L, L, L, L, H, 32'h00200113, 64'h80000004, 2'b00};
    tbl[4]  = '{L, 64'h0,        H, L, 32'h0,        L, H, L, L, L, L, H, 32'h00300193, 64'h80000008, 2'b00};
    tbl[5]  = '{L, 64'h0,        H, L, 32'h0,        L, H, L, L, L, L, L, 32'h0,        64'h0,        2'b00};
    tbl[6]  = '{H, 64'h80000002, H, L, 32'h0,        L, H, L, L, L, L, L, 32'h0,        64'h0,        2'b00};
    tbl[7]  = '{H, 64'h80000010, H, L, 32'h0,        L, L, L, L, L, H, H, NOP,          64'h80000002, 2'b10};
    tbl[8]  = '{L, 64'h0,        H, H, 32'hDEADBEEF, H, H, L, L, L, L, H, NOP,          64'h80000002, 2'b10};
    tbl[9]  = '{L, 64'h0,        H, L, 32'h0,        L, H, L, L, L, L, H, NOP,          64'h80000010, 2'b01};
    tbl[10] = '{L, 64'h0,        H, L, 32'h0,        L, H, L, L, L, L, L, 32'h0,        64'h0,        2'b00};

    rst             = 1'b0;
    fetch_req_i     = 1'b0;
    fetch_pc_i      = '0;
    ic_req_ready_i  = 1'b0;
    ic_resp_valid_i = 1'b0;
    ic_resp_data_i  = '0;
    ic_resp_err_i   = 1'b0;
    inst_ready_i    = 1'b0;
    stall_valid_i   = '0;
    flush_valid_i   = '0;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) step("tbl", tbl[i]);

    // Slow icache: two accepted, third held until the first response returns.
    step("slow", '{H, 64'h80000200, H, L, 32'h0, L, H, L, L, L, H, L, 32'h0, 64'h0, 2'b00});
    step("slow", '{H, 64'h80000204, H, L, 32'h0, L, H, L, L, L, H, L, 32'h0, 64'h0, 2'b00});
    for (int i = 0; i < 4; i++)
      step("slow", '{H, 64'h80000208, H, L, 32'h0, L, H, L, L, H, L, L, 32'h0, 64'h0, 2'b00});
    step("slow", '{H, 64'h80000208, H, H, 32'h11111111, L, H, L, L, H, L, L, 32'h0, 64'h0, 2'b00});
    step("slow", '{H, 64'h80000208, H, L, 32'h0, L, H, L, L, L, H, H, 32'h11111111, 64'h80000200, 2'b00});
    step("slow", '{L, 64'h0, H, H, 32'h22222222, L, H, L, L, L, L, L, 32'h0, 64'h0, 2'b00});
    step("slow", '{L, 64'h0, H, H, 32'h33333333, L, H, L, L, L, L, H, 32'h22222222, 64'h80000204, 2'b00});
    step("slow", '{L, 64'h0, H, L, 32'h0, L, H, L, L, L, L, H, 32'h33333333, 64'h80000208, 2'b00});

    // Flush with two in flight: both responses dropped, DRAIN until the second.
    step("flush", '{H, 64'h80000300, H, L, 32'h0, L, H, L, L, L, H, L, 32'h0, 64'h0, 2'b00});
    step("flush", '{H, 64'h80000304, H, L, 32'h0, L, H, L, L, L, H, L, 32'h0, 64'h0, 2'b00});
    step("flush", '{H, 64'h80000100, H, L, 32'h0, L, H, L, H, H, L, L, 32'h0, 64'h0, 2'b00});
    step("flush", '{H, 64'h80000100, H, L, 32'h0, L, H, L, L, H, L, L, 32'h0, 64'h0, 2'b00});
    step("flush", '{H, 64'h80000100, H, H, 32'hBAD00001, L, H, L, L, H, L, L, 32'h0, 64'h0, 2'b00});
    step("flush", '{H, 64'h80000100, H, L, 32'h0, L, H, L, L, H, L, L, 32'h0, 64'h0, 2'b00});
    step("flush", '{H, 64'h80000100, H, H, 32'hBAD00002, L, H, L, L, H, L, L, 32'h0, 64'h0, 2'b00});
    step("flush", '{H, 64'h80000100, H, L, 32'h0, L, H, L, L, L, H, L, 32'h0, 64'h0, 2'b00});
    step("flush", '{L, 64'h0, H, H, 32'h00500293, L, H, L, L, L, L, L, 32'h0, 64'h0, 2'b00});
    step("flush", '{L, 64'h0, H, L, 32'h0, L, H, L, L, L, L, H, 32'h00500293, 64'h80000100, 2'b00});

    // Flush with a queued result and a response in the same cycle: nothing left to drain.
    step("flq", '{H, 64'h80000800, H, L, 32'h0, L, L, L, L, L, H, L, 32'h0, 64'h0, 2'b00});
    step("flq", '{H, 64'h80000804, H, H, 32'h0A0A0A0A, L, L, L, L, L, H, L, 32'h0, 64'h0, 2'b00});
    step("flq", '{L, 64'h0, H, H, 32'h0B0B0B0B, L, L, L, H, L, L, H, 32'h0A0A0A0A, 64'h80000800, 2'b00});
    step("flq", '{H, 64'h80000808, H, L, 32'h0, L, H, L, L, L, H, L, 32'h0, 64'h0, 2'b00});
    step("flq", '{L, 64'h0, H, H, 32'h0C0C0C0C, L, H, L, L, L, L, L, 32'h0, 64'h0, 2'b00});
    step("flq", '{L, 64'h0, H, L, 32'h0, L, H, L, L, L, L, H, 32'h0C0C0C0C, 64'h80000808, 2'b00});

    // Misaligned PC behind one outstanding request.
    step("mis", '{H, 64'h80000400, H, L, 32'h0, L, H, L, L, L, H, L, 32'h0, 64'h0, 2'b00});
    step("mis", '{H, 64'h80000402, H, L, 32'h0, L, H, L, L, H, L, L, 32'h0, 64'h0, 2'b00});
    step("mis", '{H, 64'h80000402, H, H, 32'h00700393, L, H, L, L, H, L, L, 32'h0, 64'h0, 2'b00});
    step("mis", '{H, 64'h80000402, H, L, 32'h0, L, H, L, L, L, L, H, 32'h00700393, 64'h80000400, 2'b00});
    step("mis", '{L, 64'h0, H, L, 32'h0, L, H, L, L, L, L, H, NOP, 64'h80000402, 2'b10});
    step("mis", '{L, 64'h0, H, L, 32'h0, L, H, L, L, L, L, L, 32'h0, 64'h0, 2'b00});

    // Decode stall for 4 cycles with a full queue.
    step("stall", '{H, 64'h80000500, H, L, 32'h0, L, L, L, L, L, H, L, 32'h0, 64'h0, 2'b00});
    step("stall", '{H, 64'h80000504, H, H, 32'h5A5A0001, L, L, L, L, L, H, L, 32'h0, 64'h0, 2'b00});
    step("stall", '{H, 64'h80000508, H, H, 32'h5A5A0002, L, L, L, L, H, L, H, 32'h5A5A0001, 64'h80000500, 2'b00});
    for (int i = 0; i < 4; i++)
      step("stall", '{H, 64'h80000508, H, L, 32'h0, L, H, H, L, H, L, H, 32'h5A5A0001, 64'h80000500, 2'b00});
    step("stall", '{H, 64'h80000508, H, L, 32'h0, L, H, L, L, L, H, H, 32'h5A5A0001, 64'h80000500, 2'b00});
    step("stall", '{L, 64'h0, H, H, 32'h5A5A0003, L, H, L, L, L, L, H, 32'h5A5A0002, 64'h80000504, 2'b00});
    step("stall", '{L, 64'h0, H, L, 32'h0, L, H, L, L, L, L, H, 32'h5A5A0003, 64'h80000508, 2'b00});
    step("stall", '{L, 64'h0, H, L, 32'h0, L, H, L, L, L, L, L, 32'h0, 64'h0, 2'b00});

    // Async reset in the middle of a response cycle.
    step("arst", '{H, 64'h80000600, H, L, 32'h0, L, L, L, L, L, H, L, 32'h0, 64'h0, 2'b00});
    step("arst", '{H, 64'h80000604, H, H, 32'hF0F00001, L, L, L, L, L, H, L, 32'h0, 64'h0, 2'b00});
    fetch_req_i     = 1'b1;
    fetch_pc_i      = 64'h80000608;
    ic_resp_valid_i = 1'b1;
    ic_resp_data_i  = 32'hF0F00002;
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outputs("arst.mid");
    @(negedge clk);
    rst = 1'b1;
    step("arst", '{H, 64'h80000700, H, L, 32'h0, L, H, L, L, L, H, L, 32'h0, 64'h0, 2'b00});
    step("arst", '{L, 64'h0, H, H, 32'h00900493, L, H, L, L, L, L, L, 32'h0, 64'h0, 2'b00});
    step("arst", '{L, 64'h0, H, L, 32'h0, L, H, L, L, L, L, H, 32'h00900493, 64'h80000700, 2'b00});
    step("arst", '{L, 64'h0, H, L, 32'h0, L, H, L, L, L, L, L, 32'h0, 64'h0, 2'b00});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
